// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM state encoding,
// ADC channel field width and a ceiling-log2 helper for sizing counters.
package adc_scan_pkg;

  localparam int ADC_CH_W = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RSP = 3'd2,
    STORE    = 3'd3,
    NEXT     = 3'd4
  } scan_state_e;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Avalon-ST command/response link between the scan sequencer (master) and
// the modular-ADC sequencer core (slave).
interface adc_scan_sequencer_if
  import adc_scan_pkg::*;
#(
  parameter int DATA_W = 12
) ();

  logic                cmd_valid;
  logic [ADC_CH_W-1:0] cmd_channel;
  logic                cmd_startofpacket;
  logic                cmd_endofpacket;
  logic                cmd_ready;
  logic                rsp_valid;
  logic [ADC_CH_W-1:0] rsp_channel;
  logic [DATA_W-1:0]   rsp_data;

  modport master (
    output cmd_valid, cmd_channel, cmd_startofpacket, cmd_endofpacket,
    input  cmd_ready, rsp_valid, rsp_channel, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_channel, cmd_startofpacket, cmd_endofpacket,
    output cmd_ready, rsp_valid, rsp_channel, rsp_data
  );

endinterface

// File: rtl/adc_scan_timer.sv
// Scan-rate timer: free-running period counter gated by enable, producing a
// one-cycle tick in the cycle after the counter wraps back to zero.
module adc_scan_timer
  import adc_scan_pkg::*;
#(
  parameter int SCAN_PERIOD = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (SCAN_PERIOD > 1) ? clog2(SCAN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_s;
  logic             tick_r;

  assign wrap_s = (cnt_r == CNT_LAST);
  assign tick   = tick_r;

  // Period counter: counts 0..SCAN_PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!enable || wrap_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Registered tick, visible while the counter sits at zero after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= enable && wrap_s;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: walks CH_LIST once per scan tick, averages 2**AVG_LOG2
// conversions per channel through the ADC core's command/response streams,
// and publishes per-slot results, a scan-done pulse and sticky error flags.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int                         NUM_CH      = 2,
  parameter logic [NUM_CH*ADC_CH_W-1:0] CH_LIST     = {5'd2, 5'd1},
  parameter int                         DATA_W      = 12,
  parameter int                         AVG_LOG2    = 2,
  parameter int                         SCAN_PERIOD = 50000,
  parameter int                         RSP_TIMEOUT = 255
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       enable,
  adc_scan_sequencer_if.master       adc,
  output logic [NUM_CH*DATA_W-1:0]   result,
  output logic [NUM_CH-1:0]          result_valid,
  output logic                       scan_done,
  output logic                       err_chan,
  output logic                       err_timeout,
  input  logic                       err_clear
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SMP_W  = AVG_LOG2 + 1;
  localparam int SLOT_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int TO_W   = clog2(RSP_TIMEOUT + 1);

  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RSP_TIMEOUT - 1);

  scan_state_e         state_r, state_next;
  logic [SLOT_W-1:0]   slot_r, slot_next;
  logic [SMP_W-1:0]    smp_cnt_r;
  logic [ACC_W-1:0]    acc_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic                cmd_valid_r;
  logic [ADC_CH_W-1:0] cmd_channel_r;
  logic [NUM_CH*DATA_W-1:0] result_r;
  logic [NUM_CH-1:0]   result_valid_r;
  logic                scan_done_r;
  logic                err_chan_r;
  logic                err_timeout_r;

  logic tick_s;
  logic start_s, accept_s, rsp_take_s, rsp_match_s, timeout_s;
  logic store_s, advance_s, scan_done_s;
  logic last_sample_s, last_slot_s;
  logic [DATA_W-1:0] avg_s;

  // Channel number configured for a given slot.
  function automatic logic [ADC_CH_W-1:0] slot_channel(input logic [SLOT_W-1:0] s);
    return CH_LIST[32'(s)*ADC_CH_W +: ADC_CH_W];
  endfunction

  adc_scan_timer #(
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_timer (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .enable (enable),
    .tick   (tick_s)
  );

  assign rsp_match_s   = (adc.rsp_channel == slot_channel(slot_r));
  assign last_sample_s = (smp_cnt_r == SMP_LAST);
  assign last_slot_s   = (slot_r == SLOT_LAST);
  assign avg_s         = DATA_W'(acc_r >> AVG_LOG2);

  assign adc.cmd_valid         = cmd_valid_r;
  assign adc.cmd_channel       = cmd_channel_r;
  assign adc.cmd_startofpacket = cmd_valid_r;
  assign adc.cmd_endofpacket   = cmd_valid_r;
  assign result                = result_r;
  assign result_valid          = result_valid_r;
  assign scan_done             = scan_done_r;
  assign err_chan              = err_chan_r;
  assign err_timeout           = err_timeout_r;

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state decode and datapath strobes; enable loss is honoured only at
  // decision points so an accepted command always sees its response.
  always_comb begin
    state_next  = state_r;
    start_s     = 1'b0;
    accept_s    = 1'b0;
    rsp_take_s  = 1'b0;
    timeout_s   = 1'b0;
    store_s     = 1'b0;
    advance_s   = 1'b0;
    scan_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s && enable) begin
          start_s    = 1'b1;
          state_next = SEND;
        end else begin
          state_next = IDLE;
        end
      end
      SEND: begin
        if (adc.cmd_ready) begin
          accept_s   = 1'b1;
          state_next = WAIT_RSP;
        end else begin
          state_next = SEND;
        end
      end
      WAIT_RSP: begin
        if (adc.rsp_valid) begin
          rsp_take_s = 1'b1;
          if (last_sample_s) begin
            state_next = STORE;
          end else if (!enable) begin
            state_next = IDLE;
          end else begin
            state_next = SEND;
          end
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s  = 1'b1;
          state_next = NEXT;
        end else begin
          state_next = WAIT_RSP;
        end
      end
      STORE: begin
        store_s    = 1'b1;
        state_next = enable ? NEXT : IDLE;
      end
      NEXT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (last_slot_s) begin
          scan_done_s = 1'b1;
          state_next  = IDLE;
        end else begin
          advance_s  = 1'b1;
          state_next = SEND;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slot index for the next cycle.
  always_comb begin
    slot_next = slot_r;
    if (start_s) begin
      slot_next = '0;
    end else if (advance_s) begin
      slot_next = slot_r + SLOT_W'(1);
    end else begin
      slot_next = slot_r;
    end
  end

  // Slot pointer, sample counter and accumulator.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      slot_r    <= '0;
      smp_cnt_r <= '0;
      acc_r     <= '0;
    end else begin
      slot_r <= slot_next;
      if (start_s || advance_s) begin
        smp_cnt_r <= '0;
        acc_r     <= '0;
      end else if (rsp_take_s) begin
        smp_cnt_r <= smp_cnt_r + SMP_W'(1);
        if (rsp_match_s) begin
          acc_r <= acc_r + ACC_W'(adc.rsp_data);
        end
      end
    end
  end

  // Response timeout counter, restarted on every accepted command.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      to_cnt_r <= '0;
    end else if (accept_s) begin
      to_cnt_r <= '0;
    end else if (state_r == WAIT_RSP) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Registered command outputs, driven from the state being entered.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_valid_r   <= 1'b0;
      cmd_channel_r <= '0;
    end else begin
      cmd_valid_r   <= (state_next == SEND);
      cmd_channel_r <= slot_channel(slot_next);
    end
  end

  // Per-slot averaged results and their valid flags.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      result_r       <= '0;
      result_valid_r <= '0;
    end else if (store_s) begin
      result_r[32'(slot_r)*DATA_W +: DATA_W] <= avg_s;
      result_valid_r[slot_r]                 <= 1'b1;
    end
  end

  // Scan-done pulse and sticky error flags; a new error beats err_clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scan_done_r   <= 1'b0;
      err_chan_r    <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      scan_done_r <= scan_done_s;
      if (rsp_take_s && !rsp_match_s) begin
        err_chan_r <= 1'b1;
      end else if (err_clear) begin
        err_chan_r <= 1'b0;
      end
      if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end else if (err_clear) begin
        err_timeout_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: plays the ADC core, queues the
// expected per-slot averages as responses are driven and checks them once
// the scan completes.
module tb_adc_scan_sequencer;
  import adc_scan_pkg::*;

  localparam int NUM_CH      = 2;
  localparam int DATA_W      = 12;
  localparam int AVG_LOG2    = 2;
  localparam int SCAN_PERIOD = 40;
  localparam int RSP_TIMEOUT = 255;

  logic                     clk_clk;
  logic                     reset_reset_n;
  logic                     enable;
  logic                     err_clear;
  logic [NUM_CH*DATA_W-1:0] result;
  logic [NUM_CH-1:0]        result_valid;
  logic                     scan_done;
  logic                     err_chan;
  logic                     err_timeout;

  adc_scan_sequencer_if #(.DATA_W(DATA_W)) bus ();

  adc_scan_sequencer #(
    .NUM_CH      (NUM_CH),
    .CH_LIST     ({5'd2, 5'd1}),
    .DATA_W      (DATA_W),
    .AVG_LOG2    (AVG_LOG2),
    .SCAN_PERIOD (SCAN_PERIOD),
    .RSP_TIMEOUT (RSP_TIMEOUT)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .adc           (bus),
    .result        (result),
    .result_valid  (result_valid),
    .scan_done     (scan_done),
    .err_chan      (err_chan),
    .err_timeout   (err_timeout),
    .err_clear     (err_clear)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int slot;
    int value;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic accept_cmd(input int ch);
    bit ok;
    wait_cmd(ok);
    check("cmd_wait", 64'(ok), 64'd1);
    check("cmd_channel", 64'(bus.cmd_channel), 64'(ch));
    check("cmd_sop_eop", 64'({bus.cmd_startofpacket, bus.cmd_endofpacket}), 64'd3);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    check("cmd_single_accept", 64'(bus.cmd_valid), 64'd0);
  endtask

  task automatic send_rsp(input int ch, input int data);
    bus.rsp_valid   = 1'b1;
    bus.rsp_channel = 5'(ch);
    bus.rsp_data    = 12'(data);
    step();
    bus.rsp_valid   = 1'b0;
  endtask

  task automatic slot_beats(input int ch, input int d0, input int d1, input int d2, input int d3);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      accept_cmd(ch);
      send_rsp(ch, d[i]);
    end
  endtask

  task automatic push_exp(input int slot, input int value);
    exp_t e;
    e.slot  = slot;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic finish_scan();
    int   pulses;
    exp_t e;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (scan_done === 1'b1) pulses++;
    end
    check("scan_done_pulses", 64'(pulses), 64'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("result_slot%0d", e.slot), 64'(result[e.slot*DATA_W +: DATA_W]), 64'(e.value));
    end
    check("result_valid", 64'(result_valid), 64'd3);
  endtask

  initial begin
    int  k;
    int  cnt_valid;
    int  cnt_done;
    bit  ok;

    reset_reset_n   = 1'b0;
    enable          = 1'b0;
    err_clear       = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_channel = '0;
    bus.rsp_data    = '0;
    repeat (3) step();
    check("reset_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_outputs", 64'({result_valid, scan_done, err_chan, err_timeout}), 64'd0);
    reset_reset_n = 1'b1;
    step();

    // Averaging: ch1 100,102,104,106 -> 103; ch2 400 x4 -> 400.
    enable = 1'b1;
    push_exp(0, (100 + 102 + 104 + 106) / 4);
    slot_beats(1, 100, 102, 104, 106);
    check("no_early_done", 64'(scan_done), 64'd0);
    push_exp(1, 400);
    slot_beats(2, 400, 400, 400, 400);
    finish_scan();

    // Back-pressure: command held stable for 7 stalled cycles.
    wait_cmd(ok);
    check("stall_cmd_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("stall_hold%0d", i), 64'({bus.cmd_valid, bus.cmd_channel}), 64'({1'b1, 5'd1}));
      step();
    end
    push_exp(0, 200);
    slot_beats(1, 200, 200, 200, 200);
    push_exp(1, (8 + 9 + 10 + 11) / 4);
    slot_beats(2, 8, 9, 10, 11);
    finish_scan();
    check("err_chan_clean", 64'(err_chan), 64'd0);

    // Channel mismatch contributes 0: (100+0+104+106)>>2 = 77; full-scale slot 1.
    push_exp(0, (100 + 104 + 106) / 4);
    accept_cmd(1);
    send_rsp(1, 100);
    accept_cmd(1);
    send_rsp(5, 999);
    check("err_chan_set", 64'(err_chan), 64'd1);
    accept_cmd(1);
    send_rsp(1, 104);
    accept_cmd(1);
    send_rsp(1, 106);
    push_exp(1, 4095);
    slot_beats(2, 4095, 4095, 4095, 4095);
    finish_scan();
    check("err_chan_sticky", 64'(err_chan), 64'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("err_chan_cleared", 64'(err_chan), 64'd0);

    // Response outside WAIT_RSP is ignored.
    send_rsp(7, 123);
    check("stray_rsp_no_err", 64'(err_chan), 64'd0);
    check("stray_rsp_result", 64'(result), 64'({12'd4095, 12'd77}));

    // Timeout: no response for slot 0; slot kept, slot 1 still serviced.
    accept_cmd(1);
    for (k = 1; k <= 300; k++) begin
      step();
      if (err_timeout === 1'b1) break;
    end
    check("timeout_latency", 64'(k), 64'(RSP_TIMEOUT));
    push_exp(0, 77);
    push_exp(1, 50);
    slot_beats(2, 50, 50, 50, 50);
    finish_scan();
    check("err_timeout_sticky", 64'(err_timeout), 64'd1);

    // Enable dropped while waiting: response consumed, scan abandoned quietly.
    accept_cmd(1);
    enable = 1'b0;
    send_rsp(1, 300);
    cnt_valid = 0;
    cnt_done  = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_valid === 1'b1) cnt_valid++;
      if (scan_done === 1'b1) cnt_done++;
      step();
    end
    check("disabled_no_cmd", 64'(cnt_valid), 64'd0);
    check("disabled_no_done", 64'(cnt_done), 64'd0);
    check("disabled_retain", 64'(result), 64'({12'd50, 12'd77}));

    // Re-enable restarts at slot 0; then reset while the command is pending.
    enable = 1'b1;
    wait_cmd(ok);
    check("restart_cmd_seen", 64'(ok), 64'd1);
    check("restart_slot0_ch", 64'(bus.cmd_channel), 64'd1);
    reset_reset_n = 1'b0;
    #1;
    check("async_reset_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("async_reset_result", 64'(result), 64'd0);
    check("async_reset_flags", 64'({result_valid, scan_done, err_chan, err_timeout}), 64'd0);
    step();
    reset_reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Parametrised scan controller sitting between game logic and the modular-ADC sequencer core.
- Drives the core's Avalon-ST command port and consumes its response port.
- Walks a configurable channel list at a programmable scan rate, averaging 2^AVG_LOG2 conversions per channel.
- Publishes per-channel latest results with valid flags, scan-done pulse and error flags. Replaces ad-hoc single-channel command logic used for joystick/paddle inputs.

Parameters:
- NUM_CH, 2, number of channels scanned (1..8)
- CH_LIST, {5'd2,5'd1}, packed NUM_CH*5 channel numbers; slot 0 in LSBs
- DATA_W, 12, ADC sample width
- AVG_LOG2, 2, log2 of conversions averaged per channel (0..4)
- SCAN_PERIOD, 50000, clk_clk cycles between scan starts (>= 1)
- RSP_TIMEOUT, 255, cycles allowed from command accept to response

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = scanning permitted
- cmd_valid  out  1  command valid to ADC core
- cmd_channel  out  5  channel of current command
- cmd_startofpacket  out  1  =1 whenever cmd_valid
- cmd_endofpacket  out  1  =1 whenever cmd_valid
- cmd_ready  in  1  core accepts command
- rsp_valid  in  1  response beat valid
- rsp_channel  in  5  channel of response
- rsp_data  in  DATA_W  sample
- result  out  NUM_CH*DATA_W  averaged result per slot, slot 0 in LSBs
- result_valid  out  NUM_CH  bit i set once slot i has a result
- scan_done  out  1  one-cycle pulse after last slot written
- err_chan  out  1  sticky: response channel mismatch
- err_timeout  out  1  sticky: response timeout
- err_clear  in  1  synchronous clear of both sticky errors

Behaviour:
- Async reset (reset_reset_n=0): all outputs 0, result=0, state IDLE, period counter 0, slot 0, accumulator 0.
- Period counter free-runs 0..SCAN_PERIOD-1 while enable=1, held at 0 when enable=0; tick when counter wraps to 0.
- FSM states:
  - IDLE: on tick and enable, go to SEND with slot=0, sample count=0, acc=0.
  - SEND: cmd_valid=1, cmd_channel=CH_LIST[slot]. cmd_valid and cmd_channel stay stable until cmd_ready. Handshake completes on the cycle where cmd_valid&cmd_ready; then go to WAIT_RSP and clear the timeout counter.
  - WAIT_RSP: on rsp_valid:
    - rsp_channel matches: acc += rsp_data.
    - Mismatch: set err_chan and discard the sample; it counts as a consumed sample contributing 0.
    - Either way, increment sample count. If count == 2^AVG_LOG2, go to STORE; else go to SEND.
    - If the counter reaches RSP_TIMEOUT without rsp_valid: set err_timeout, abandon the slot (result and valid bit unchanged), go to NEXT.
  - STORE: result[slot] = acc >> AVG_LOG2 (truncating); set result_valid[slot]; go to NEXT.
  - NEXT: if slot == NUM_CH-1, pulse scan_done and go to IDLE; else slot++, count=0, acc=0, go to SEND.
- Accumulator width DATA_W+AVG_LOG2; no overflow possible.
- rsp_valid outside WAIT_RSP is ignored (no error).
- Tick arriving while not in IDLE is dropped; no queued scans.
- enable falling mid-scan: the outstanding command/response completes normally (SEND may not drop cmd_valid). Return to IDLE at the next decision point (after STORE, or at the SEND entry of a new beat); no scan_done. Results retain their values.
- Minimum latency, AVG_LOG2=0: tick -> cmd_valid next cycle; rsp_valid -> result update 1 cycle later (STORE); scan_done 1 cycle after the last STORE.
- Errors are sticky until err_clear or reset. err_clear in the same cycle as a new error event: the set wins.

Decomposition:
- Package adc_scan_pkg: FSM state enum (IDLE, SEND, WAIT_RSP, STORE, NEXT), ADC_CH_W=5, slot-index width function clog2.
- One sub-module, adc_scan_timer: period counter and tick generation with enable gating. Everything else stays in the top level.

Test Plan:
- NUM_CH=2, AVG_LOG2=2, core responds with 100,102,104,106 on ch1 then 400 x4 on ch2 -> result slot0=103, slot1=400, result_valid=2'b11, one scan_done pulse.
- cmd_ready held 0 for 7 cycles -> cmd_valid/cmd_channel stable all 7 cycles, exactly one command accepted.
- Response with rsp_channel=5 while expecting 1 -> err_chan=1 and stays 1; with AVG_LOG2=0, slot result=0. err_clear pulse -> err_chan=0.
- No response, RSP_TIMEOUT=255 -> err_timeout set 255 cycles after accept, slot unchanged, next slot's command issued.
- enable dropped during WAIT_RSP -> response consumed, no further cmd_valid, no scan_done; re-enable -> scan restarts at slot 0 on next tick.
- reset_reset_n asserted mid-SEND -> cmd_valid=0 immediately (async), result/result_valid/errors all 0.
